// File: rtl/alu_seq_pkg.sv
// Shared opcodes, state and settle-class types for the ALU result sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SHRA = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT_LO = 2'd2,
    ST_OUT_HI = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    CLS_BASIC = 2'd0,
    CLS_MUL   = 2'd1,
    CLS_DIV   = 2'd2
  } settle_cls_e;

  function automatic logic is_two_beat(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic settle_cls_e settle_sel(input logic [3:0] op);
    case (op)
      OP_MUL:  return CLS_MUL;
      OP_DIV:  return CLS_DIV;
      default: return CLS_BASIC;
    endcase
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that stops at zero and flags it; paces the ALU settle window.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_result_sequencer.sv
// Issue/collect front end for the combinational ALU: holds operands for the op's
// settle time, captures the 64-bit result, then returns it as one or two 32-bit beats.
//
// state     | meaning
// ST_IDLE   | ready for a request; alu_* hold the last accepted operands
// ST_SETTLE | ALU inputs held; timer counts down to the capture cycle
// ST_OUT_LO | Z_LO beat presented, waiting for out_ready
// ST_OUT_HI | Z_HI beat presented (MUL/DIV only), waiting for out_ready
module alu_result_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_BASIC = 1,
  parameter int SETTLE_MUL   = 4,
  parameter int SETTLE_DIV   = 8
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [63:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_hi,
  output logic        out_last,
  output logic        out_err,
  output logic        busy
);

  localparam int SETTLE_MAX_BM = (SETTLE_BASIC > SETTLE_MUL) ? SETTLE_BASIC : SETTLE_MUL;
  localparam int SETTLE_MAX    = (SETTLE_MAX_BM > SETTLE_DIV) ? SETTLE_MAX_BM : SETTLE_DIV;
  localparam int CNT_W         = $clog2(SETTLE_MAX) + 1;

  seq_state_e  state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] z_hi_q, z_hi_d, z_lo_q, z_lo_d;
  logic        two_beat_q, two_beat_d, err_q, err_d;
  logic        accept, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val;

  assign accept = (state_q == ST_IDLE) && req_valid;

  // Timer holds N-1 so that capture lands exactly N edges after the accept.
  always_comb begin
    tmr_load_val = CNT_W'(SETTLE_BASIC - 1);
    case (settle_sel(req_op))
      CLS_MUL: tmr_load_val = CNT_W'(SETTLE_MUL - 1);
      CLS_DIV: tmr_load_val = CNT_W'(SETTLE_DIV - 1);
      default: tmr_load_val = CNT_W'(SETTLE_BASIC - 1);
    endcase
  end

  settle_timer #(.W(CNT_W)) u_settle_timer (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (accept),
    .load_val (tmr_load_val),
    .dec      (state_q == ST_SETTLE),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_SETTLE;
      ST_SETTLE: if (tmr_zero)  state_d = ST_OUT_LO;
      ST_OUT_LO: if (out_ready) state_d = two_beat_q ? ST_OUT_HI : ST_IDLE;
      ST_OUT_HI: if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_hi    = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      ST_OUT_LO: begin
        out_valid = 1'b1;
        out_data  = z_lo_q;
        out_last  = !two_beat_q;
      end
      ST_OUT_HI: begin
        out_valid = 1'b1;
        out_data  = z_hi_q;
        out_hi    = 1'b1;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_err   = out_valid & err_q;
  assign busy      = (state_q != ST_IDLE);
  assign req_ready = (state_q == ST_IDLE);

  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    two_beat_d = two_beat_q;
    err_d      = err_q;
    z_hi_d     = z_hi_q;
    z_lo_d     = z_lo_q;
    if (accept) begin
      alu_a_d    = req_a;
      alu_b_d    = req_b;
      alu_op_d   = req_op;
      two_beat_d = is_two_beat(req_op);
      err_d      = (req_op == OP_DIV) && (req_b == '0);
    end
    if ((state_q == ST_SETTLE) && tmr_zero)
      {z_hi_d, z_lo_d} = alu_result;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      two_beat_q <= 1'b0;
      err_q      <= 1'b0;
      z_hi_q     <= '0;
      z_lo_q     <= '0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      two_beat_q <= two_beat_d;
      err_q      <= err_d;
      z_hi_q     <= z_hi_d;
      z_lo_q     <= z_lo_d;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

endmodule

// File: tb/tb_alu_result_sequencer.sv
// Bench for alu_result_sequencer: reference ALU on the alu_* ports, a transaction-level
// model checked every cycle, and directed ops with hand-computed results.
module tb_alu_result_sequencer;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_hi, out_last, out_err, busy;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_result_sequencer dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_hi     (out_hi),
    .out_last   (out_last),
    .out_err    (out_err),
    .busy       (busy)
  );

  function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [63:0] r, sa, sb, t;
    int q, rm;
    r  = 64'd0;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      4'd0:  r[31:0] = a | b;
      4'd1:  r[31:0] = a & b;
      4'd2:  r[31:0] = ~a;
      4'd3:  r[31:0] = a + b;
      4'd4:  r[31:0] = a - b;
      4'd5:  r[31:0] = -a;
      4'd6:  r = sa * sb;
      4'd7: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q  = $signed(a) / $signed(b);
          rm = $signed(a) % $signed(b);
          r  = {rm, q};
        end
      end
      4'd8:  r[31:0] = a << b[4:0];
      4'd9:  r[31:0] = a >> b[4:0];
      4'd10: r[31:0] = $signed(a) >>> b[4:0];
      4'd11: begin t = {a, a} << b[4:0]; r[31:0] = t[63:32]; end
      4'd12: begin t = {a, a} >> b[4:0]; r[31:0] = t[31:0]; end
      default: r = {32'hDEAD_0000 | {28'd0, op}, a ^ b};
    endcase
    return r;
  endfunction

  assign alu_result = ref_alu(alu_a, alu_b, alu_op);

  function automatic int settle_cycles(input logic [3:0] op);
    if (op == 4'd6) return 4;
    if (op == 4'd7) return 8;
    return 1;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        hi;
    logic        last;
    logic        err;
  } beat_t;

  beat_t       mq[$];
  int          m_wait = 0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic [3:0]  m_op = 4'd0;
  logic [63:0] m_res = 64'd0;
  logic        m_two = 1'b0, m_errf = 1'b0;

  // Transaction model: an accepted op waits N edges, then its beats sit in a queue.
  initial forever begin
    @(posedge clk or negedge clr_n);
    if (!clr_n) begin
      m_wait = 0;
      mq.delete();
      m_a = 32'd0; m_b = 32'd0; m_op = 4'd0;
    end else if (m_wait == 0 && mq.size() == 0) begin
      if (req_valid) begin
        m_a    = req_a;
        m_b    = req_b;
        m_op   = req_op;
        m_res  = ref_alu(req_a, req_b, req_op);
        m_two  = (req_op == 4'd6) || (req_op == 4'd7);
        m_errf = (req_op == 4'd7) && (req_b == 32'd0);
        m_wait = settle_cycles(req_op);
      end
    end else if (m_wait != 0) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        mq.push_back('{m_res[31:0], 1'b0, !m_two, m_errf});
        if (m_two) mq.push_back('{m_res[63:32], 1'b1, 1'b1, m_errf});
      end
    end else if (out_ready) begin
      void'(mq.pop_front());
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    logic idle;
    beat_t b;
    @(negedge clk);
    if (cmp_en) begin
      idle = (m_wait == 0) && (mq.size() == 0);
      if (mq.size() != 0) b = mq[0];
      else b = '{32'd0, 1'b0, 1'b0, 1'b0};
      check("m_req_ready", req_ready, idle);
      check("m_busy", busy, !idle);
      check("m_out_valid", out_valid, mq.size() != 0);
      check("m_out_data", out_data, b.data);
      check("m_out_hi", out_hi, b.hi);
      check("m_out_last", out_last, b.last);
      check("m_out_err", out_err, b.err);
      check("m_alu_a", alu_a, m_a);
      check("m_alu_b", alu_b, m_b);
      check("m_alu_op", alu_op, m_op);
    end
  end

  // Starts and ends at posedge+2; out_ready is assumed high.
  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int n, input logic [31:0] e_lo,
                       input logic [31:0] e_hi, input logic two, input logic e_err);
    int lat;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    #1;
    check({nm, "_busy_after_accept"}, busy, 1'b1);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check({nm, "_latency"}, lat, n);
    check({nm, "_lo_data"}, out_data, e_lo);
    check({nm, "_lo_hi"}, out_hi, 1'b0);
    check({nm, "_lo_last"}, out_last, !two);
    check({nm, "_lo_err"}, out_err, e_err);
    if (two) begin
      @(posedge clk);
      #1;
      check({nm, "_hi_valid"}, out_valid, 1'b1);
      check({nm, "_hi_data"}, out_data, e_hi);
      check({nm, "_hi_hi"}, out_hi, 1'b1);
      check({nm, "_hi_last"}, out_last, 1'b1);
      check({nm, "_hi_err"}, out_err, e_err);
    end
    @(posedge clk);
    #1;
    check({nm, "_done_valid"}, out_valid, 1'b0);
    check({nm, "_done_ready"}, req_ready, 1'b1);
    #1;
  endtask

  initial begin
    int lat, seen;
    #1 clr_n = 1'b0;
    #2 cmp_en = 1'b1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_alu_op", alu_op, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #2 clr_n = 1'b1;
    @(posedge clk);
    #2;

    do_op("add",    4'd3,  32'd5,          32'd7,          1, 32'h0000_000C, 32'd0,         1'b0, 1'b0);
    do_op("mul",    4'd6,  32'hFFFF_FFFF,  32'd2,          4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("div",    4'd7,  32'd17,         32'd5,          8, 32'd3,         32'd2,         1'b1, 1'b0);
    do_op("div0",   4'd7,  32'd17,         32'd0,          8, 32'hFFFF_FFFF, 32'd17,        1'b1, 1'b1);
    do_op("sub",    4'd4,  32'd5,          32'd7,          1, 32'hFFFF_FFFE, 32'd0,         1'b0, 1'b0);
    do_op("shra",   4'd10, 32'h8000_0000,  32'd4,          1, 32'hF800_0000, 32'd0,         1'b0, 1'b0);
    do_op("rol",    4'd11, 32'h8000_0001,  32'd1,          1, 32'h0000_0003, 32'd0,         1'b0, 1'b0);
    do_op("op13",   4'd13, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  1, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);
    do_op("b2b",    4'd0,  32'h0000_00F0,  32'h0000_000F,  1, 32'h0000_00FF, 32'd0,         1'b0, 1'b0);

    // Backpressure in OUT_HI with requests knocking.
    out_ready = 1'b0;
    req_op = 4'd6; req_a = 32'hFFFF_FFFF; req_b = 32'd2; req_valid = 1'b1;
    @(posedge clk);
    #2 req_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      #1;
    end
    check("bp_lo_data", out_data, 32'hFFFF_FFFE);
    out_ready = 1'b1;
    @(posedge clk);
    #2 out_ready = 1'b0;
    req_op = 4'd3; req_a = 32'd9; req_b = 32'd9;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      check("bp_hi_data", out_data, 32'hFFFF_FFFF);
      check("bp_hi_flag", out_hi, 1'b1);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_alu_op", alu_op, 4'd6);
      check("bp_alu_a", alu_a, 32'hFFFF_FFFF);
      #1;
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_done_valid", out_valid, 1'b0);
    #1;

    // Reset two cycles into a divide's settle window.
    req_op = 4'd7; req_a = 32'd100; req_b = 32'd3; req_valid = 1'b1;
    @(posedge clk);
    #2 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 clr_n = 1'b0;
    req_valid = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_alu_op", alu_op, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1 check("rst_no_accept", busy, 1'b0);
    #1 req_valid = 1'b0;
    clr_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
      #1;
    end
    check("rst_no_beat", seen, 0);
    do_op("post_rst_add", 4'd3, 32'd1, 32'd1, 1, 32'h0000_0002, 32'd0, 1'b0, 1'b0);

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
